lfsr3_checker: RTL and testbench
================================

# lfsr3_checker

Receive-side companion to the 3-bit LFSR random generator. Takes the stream of 3-bit values produced by a peer generator (one value per `sample_valid`), self-synchronises to it, then predicts each next value and flags deviations. Sits on the consumer side of any path that carries the generator output, such as a test link, a game-logic consumer or a BIST loop. It reports lock status, per-sample mismatch and a running error count.

## Interface
Parameters:
- `LOCK_COUNT`, default 3: consecutive correct predictions required to declare lock (range 1–15).
- `LOSS_COUNT`, default 2: consecutive mispredictions in LOCKED that drop lock (range 1–15).
- `ERR_W`, default 16: width of the error counter.

Ports:
- `CLK`  in  1: clock. All state updates on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `sample`  in  3: received generator value.
- `locked`  out  1: checker is in LOCKED.
- `mismatch`  out  1: one-cycle pulse when a valid sample differed from the prediction while in VERIFY or LOCKED.
- `lockup`  out  1: one-cycle pulse when a valid sample equals 3'b111, the illegal stuck state.
- `expected`  out  3: current predicted value for the next valid sample.
- `err_count`  out  ERR_W: saturating count of mismatches seen in LOCKED.

## Operation
- Next-state function, applied to prediction x: n[0] = x[2] XNOR x[1]; n[1] = x[0]; n[2] = x[1].
- Legal cycle (period 7): 000→001→011→110→101→010→100→000. The value 111 maps to itself.
- States: HUNT, VERIFY, LOCKED. Cycles without `sample_valid` change nothing.
- **HUNT**, on a valid sample s:
  - If s==111: pulse `lockup` and stay in HUNT.
  - Otherwise: `expected` <= n(s), `match_cnt` <= 0, go to VERIFY.
- **VERIFY**, on a valid sample s:
  - If s==`expected`: `match_cnt`+1 and `expected` <= n(s). When `match_cnt`+1 == LOCK_COUNT, go to LOCKED with `miss_cnt` = 0.
  - If s≠`expected`: pulse `mismatch` and reseed.
    - s≠111: `expected` <= n(s), `match_cnt` <= 0, stay in VERIFY.
    - s==111: pulse `lockup` as well and go to HUNT.
- **LOCKED**, on a valid sample s:
  - If s==`expected`: `miss_cnt` <= 0.
  - If s≠`expected`: pulse `mismatch`, increment `err_count` (saturates at all-ones), `miss_cnt`+1. When `miss_cnt`+1 == LOSS_COUNT, go to HUNT.
  - In both cases `expected` <= n(`expected`). This is flywheel behaviour: bad samples never reseed the predictor.
  - A sample of 111 in LOCKED also pulses `lockup` and counts as a normal mismatch.
- `err_count` is cleared only by `RESET`. It holds its value across lock loss.

## Timing
- Reset values: state HUNT, `locked`=0, `mismatch`=0, `lockup`=0, `expected`=000, `err_count`=0, internal counters 0.
- All outputs are registered. The response to a sample presented in cycle t is visible in cycle t+1.
- `mismatch` and `lockup` are high for exactly one cycle per offending valid sample. Back-to-back bad samples give back-to-back pulses.
- `locked` rises in the cycle after the LOCK_COUNT-th correct sample following the seed sample. It falls in the cycle after the LOSS_COUNT-th consecutive miss.
- Asserting `RESET` mid-stream forces reset values immediately, regardless of the clock. The first valid sample after release is treated as a HUNT seed.

## Configuration
- `LFSR3_CHK_ERRCNT_EN` defined: the saturating ERR_W-bit `err_count` register is implemented as described.
- Undefined: no counter logic is built and `err_count` is tied to 0. `locked`, `mismatch` and `lockup` behave identically in both builds.

## Test plan
- **Acquire lock:** defaults, valid samples 000, 001, 011, 110 on consecutive cycles.
  - `locked`=1 in the cycle after 110; `expected`=101; no `mismatch`.
- **Gapped stream:** same sequence with `sample_valid` low for 2 cycles between samples.
  - Same lock result; state and `expected` frozen during gaps.
- **Flywheel in lock:** once locked, expected 101; send 000 then 010.
  - `mismatch` pulses once on the 000 only; `err_count`=1; still locked; `expected`=100 afterward.
- **Lock loss:** once locked, send 000, 000 where 101, 010 are expected.
  - Two `mismatch` pulses; `err_count`=2; `locked`=0 in the cycle after the second; next sample 011 reseeds, giving `expected`=110.
- **Illegal value:** in HUNT, send 111.
  - `lockup` pulses, state stays HUNT.
  - Then send 100: `expected`=000, state VERIFY.
- **Reset and saturation:** with ERR_W=2, force 5 misses in LOCKED with LOSS_COUNT=15.
  - `err_count` saturates at 3.
  - Asserting `RESET` mid-cycle clears all outputs to their reset values asynchronously.
  - With `LFSR3_CHK_ERRCNT_EN` undefined, `err_count` stays 0 throughout.

Source files
------------

// File: rtl/lfsr3_checker.sv
// -----------------------------------------------------------------------------
// lfsr3_checker
//
// Receive-side checker for a 3-bit LFSR generator stream. It self-synchronises
// to the incoming values, predicts each next value and flags deviations. It
// reports lock status, per-sample mismatch / lockup pulses and a running error
// count.
//
// Ports:
//   CLK          in   1      clock, rising edge
//   RESET        in   1      asynchronous, active-high reset
//   sample_valid in   1      sample is valid this cycle
//   sample       in   3      received generator value
//   locked       out  1      checker is in LOCKED
//   mismatch     out  1      one-cycle pulse: valid sample differed from the
//                            prediction (VERIFY or LOCKED)
//   lockup       out  1      one-cycle pulse: valid sample was 3'b111
//   expected     out  3      predicted value for the next valid sample
//   err_count    out  ERR_W  saturating count of mismatches seen in LOCKED
//
// Build option:
//   LFSR3_CHK_ERRCNT_EN  when defined, the saturating err_count register is
//                        built; otherwise err_count is tied to zero.
// -----------------------------------------------------------------------------
module lfsr3_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             sample_valid,
    input  logic [2:0]       sample,
    output logic             locked,
    output logic             mismatch,
    output logic             lockup,
    output logic [2:0]       expected,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);
    localparam logic [2:0] STUCK  = 3'b111;

    // Generator next-state: shift left, feed back XNOR of the two top bits.
    function automatic logic [2:0] lfsr3_next(input logic [2:0] x);
        return {x[1], x[0], ~(x[2] ^ x[1])};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] expected_q, expected_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic       mismatch_q, mismatch_d;
    logic       lockup_q, lockup_d;
    logic       locked_q, locked_d;
    logic [3:0] match_inc_s;
    logic [3:0] miss_inc_s;

    assign match_inc_s = match_cnt_q + 4'd1;
    assign miss_inc_s  = miss_cnt_q + 4'd1;

    // Next-state and next-output logic for the HUNT / VERIFY / LOCKED machine.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        mismatch_d  = 1'b0;
        lockup_d    = 1'b0;

        if (sample_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sample == STUCK) begin
                        lockup_d = 1'b1;
                    end else begin
                        expected_d  = lfsr3_next(sample);
                        match_cnt_d = 4'd0;
                        state_d     = ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    if (sample == expected_q) begin
                        match_cnt_d = match_inc_s;
                        expected_d  = lfsr3_next(sample);
                        if (match_inc_s == LOCK_C) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        // Reseed from the offending sample unless it is the
                        // stuck value, which cannot seed a legal sequence.
                        mismatch_d  = 1'b1;
                        match_cnt_d = 4'd0;
                        if (sample != STUCK) begin
                            expected_d = lfsr3_next(sample);
                            state_d    = ST_VERIFY;
                        end else begin
                            lockup_d = 1'b1;
                            state_d  = ST_HUNT;
                        end
                    end
                end

                ST_LOCKED: begin
                    lockup_d   = (sample == STUCK);
                    // Flywheel: the predictor free-runs and is never reseeded
                    // by a bad sample while locked.
                    expected_d = lfsr3_next(expected_q);
                    if (sample == expected_q) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        miss_cnt_d = miss_inc_s;
                        if (miss_inc_s == LOSS_C) begin
                            state_d = ST_HUNT;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end

                default: begin
                    state_d     = ST_HUNT;
                    expected_d  = 3'b000;
                    match_cnt_d = 4'd0;
                    miss_cnt_d  = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, prediction, counters and registered status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_HUNT;
            expected_q  <= 3'b000;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            mismatch_q  <= 1'b0;
            lockup_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            mismatch_q  <= mismatch_d;
            lockup_q    <= lockup_d;
            locked_q    <= locked_d;
        end
    end

    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign lockup   = lockup_q;
    assign expected = expected_q;

`ifdef LFSR3_CHK_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;
    logic             err_inc_s;

    // Only misses while locked are counted.
    assign err_inc_s = sample_valid && (state_q == ST_LOCKED) && (sample != expected_q);

    // Saturating increment of the error counter.
    always_comb begin
        if (err_inc_s && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Error counter register; cleared only by reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q <= {ERR_W{1'b0}};
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr3_checker.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr3_checker. Two instances share one input stream:
//   dut_a: defaults (LOCK_COUNT=3, LOSS_COUNT=2, ERR_W=16)
//   dut_b: LOCK_COUNT=3, LOSS_COUNT=15, ERR_W=2 (counter saturation)
// Each is compared every cycle with a behavioural model that walks the legal
// 7-value cycle by table lookup, plus directed constant checks.
// -----------------------------------------------------------------------------
module tb_lfsr3_checker;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    typedef struct {
        int mode;
        int exp_v;
        int match;
        int miss;
        int err;
        int mm;
        int lu;
    } mdl_t;

    logic        clk_r = 1'b0;
    logic        rst_r;
    logic        valid_r;
    logic [2:0]  sample_r;

    logic        a_locked_s, a_mismatch_s, a_lockup_s;
    logic [2:0]  a_expected_s;
    logic [15:0] a_err_s;
    logic        b_locked_s, b_mismatch_s, b_lockup_s;
    logic [2:0]  b_expected_s;
    logic [1:0]  b_err_s;

    int   checks = 0;
    int   errors = 0;
    int   cyc_tab[7];
    int   nxt_tab[8];
    mdl_t ma, mb;

    lfsr3_checker dut_a (
        .CLK(clk_r), .RESET(rst_r), .sample_valid(valid_r), .sample(sample_r),
        .locked(a_locked_s), .mismatch(a_mismatch_s), .lockup(a_lockup_s),
        .expected(a_expected_s), .err_count(a_err_s)
    );

    lfsr3_checker #(.LOCK_COUNT(3), .LOSS_COUNT(15), .ERR_W(2)) dut_b (
        .CLK(clk_r), .RESET(rst_r), .sample_valid(valid_r), .sample(sample_r),
        .locked(b_locked_s), .mismatch(b_mismatch_s), .lockup(b_lockup_s),
        .expected(b_expected_s), .err_count(b_err_s)
    );

    always #5 clk_r = ~clk_r;

    function automatic int err_view(input int e);
`ifdef LFSR3_CHK_ERRCNT_EN
        return e;
`else
        return 0;
`endif
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = M_HUNT; m.exp_v = 0; m.match = 0; m.miss = 0;
        m.err = 0; m.mm = 0; m.lu = 0;
        return m;
    endfunction

    // Behavioural reference: one valid-or-idle cycle applied to a model.
    function automatic mdl_t mdl_step(input mdl_t m, input int v, input int s,
                                      input int lockn, input int lossn, input int errmax);
        mdl_t r;
        r = m;
        r.mm = 0;
        r.lu = 0;
        if (v != 0) begin
            if (m.mode == M_HUNT) begin
                if (s == 7) r.lu = 1;
                else begin
                    r.exp_v = nxt_tab[s]; r.match = 0; r.mode = M_VERIFY;
                end
            end else if (m.mode == M_VERIFY) begin
                if (s == m.exp_v) begin
                    r.match = m.match + 1;
                    r.exp_v = nxt_tab[s];
                    if (r.match == lockn) begin
                        r.mode = M_LOCKED; r.miss = 0;
                    end
                end else begin
                    r.mm = 1;
                    r.match = 0;
                    if (s != 7) r.exp_v = nxt_tab[s];
                    else begin
                        r.lu = 1; r.mode = M_HUNT;
                    end
                end
            end else begin
                if (s == 7) r.lu = 1;
                if (s == m.exp_v) r.miss = 0;
                else begin
                    r.mm = 1;
                    r.err = (m.err < errmax) ? m.err + 1 : errmax;
                    r.miss = m.miss + 1;
                    if (r.miss == lossn) r.mode = M_HUNT;
                end
                r.exp_v = nxt_tab[m.exp_v];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_models();
        chk("a_locked",   32'(a_locked_s),   32'(ma.mode == M_LOCKED));
        chk("a_mismatch", 32'(a_mismatch_s), 32'(ma.mm));
        chk("a_lockup",   32'(a_lockup_s),   32'(ma.lu));
        chk("a_expected", 32'(a_expected_s), 32'(ma.exp_v));
        chk("a_err",      32'(a_err_s),      32'(err_view(ma.err)));
        chk("b_locked",   32'(b_locked_s),   32'(mb.mode == M_LOCKED));
        chk("b_mismatch", 32'(b_mismatch_s), 32'(mb.mm));
        chk("b_lockup",   32'(b_lockup_s),   32'(mb.lu));
        chk("b_expected", 32'(b_expected_s), 32'(mb.exp_v));
        chk("b_err",      32'(b_err_s),      32'(err_view(mb.err)));
    endtask

    // Present one cycle of input, then check both DUTs just after the edge.
    task automatic drive(input int v, input int s);
        valid_r  = (v != 0);
        sample_r = 3'(s);
        @(posedge clk_r);
        #1;
        ma = mdl_step(ma, v, s, 3, 2, 65535);
        mb = mdl_step(mb, v, s, 3, 15, 3);
        check_models();
    endtask

    // Assert reset between edges and check outputs clear before any clock.
    task automatic do_reset();
        valid_r = 1'b0;
        rst_r   = 1'b1;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check_models();
        @(posedge clk_r);
        #2;
        rst_r = 1'b0;
    endtask

    initial begin
        int g;
        int v;
        int s;
        int r;

        rst_r    = 1'b1;
        valid_r  = 1'b0;
        sample_r = 3'b000;
        cyc_tab  = '{0, 1, 3, 6, 5, 2, 4};
        for (int i = 0; i < 7; i++) nxt_tab[cyc_tab[i]] = cyc_tab[(i + 1) % 7];
        nxt_tab[7] = 7;
        ma = mdl_reset();
        mb = mdl_reset();

        #12;
        check_models();
        rst_r = 1'b0;
        #1;

        // Acquire lock on consecutive samples.
        drive(1, 0); drive(1, 1); drive(1, 3); drive(1, 6);
        chk("acq_locked",   32'(a_locked_s),   32'd1);
        chk("acq_expected", 32'(a_expected_s), 32'd5);
        chk("acq_mismatch", 32'(a_mismatch_s), 32'd0);

        // Lock loss: two misses against expected 101, 010.
        drive(1, 0);
        chk("loss_mm1", 32'(a_mismatch_s), 32'd1);
        drive(1, 0);
        chk("loss_mm2",    32'(a_mismatch_s), 32'd1);
        chk("loss_locked", 32'(a_locked_s),   32'd0);
        chk("loss_err",    32'(a_err_s),      32'(err_view(2)));
        drive(1, 3);
        chk("reseed_expected", 32'(a_expected_s), 32'd6);
        chk("reseed_mismatch", 32'(a_mismatch_s), 32'd0);

        // Gapped acquisition, then flywheel behaviour.
        do_reset();
        drive(1, 0); drive(0, 0);
        chk("gap_frozen", 32'(a_expected_s), 32'd1);
        drive(0, 5);
        chk("gap_frozen2", 32'(a_expected_s), 32'd1);
        drive(1, 1); drive(0, 0); drive(0, 0);
        drive(1, 3); drive(0, 2); drive(0, 0);
        drive(1, 6);
        chk("gap_locked",   32'(a_locked_s),   32'd1);
        chk("gap_expected", 32'(a_expected_s), 32'd5);
        drive(1, 0);
        chk("fly_mm",  32'(a_mismatch_s), 32'd1);
        chk("fly_err", 32'(a_err_s),      32'(err_view(1)));
        drive(1, 2);
        chk("fly_mm_clear", 32'(a_mismatch_s), 32'd0);
        chk("fly_locked",   32'(a_locked_s),   32'd1);
        chk("fly_expected", 32'(a_expected_s), 32'd4);

        // Illegal value in HUNT, reseed, then saturation on dut_b.
        do_reset();
        drive(1, 7);
        chk("ill_lockup", 32'(a_lockup_s), 32'd1);
        chk("ill_locked", 32'(a_locked_s), 32'd0);
        drive(0, 0);
        chk("ill_lockup_pulse", 32'(a_lockup_s), 32'd0);
        drive(1, 4);
        chk("ill_reseed", 32'(a_expected_s), 32'd0);
        drive(1, 0); drive(1, 1); drive(1, 3);
        chk("sat_locked", 32'(b_locked_s), 32'd1);
        for (int k = 0; k < 5; k++) drive(1, 7);
        chk("sat_err",     32'(b_err_s),    32'(err_view(3)));
        chk("sat_locked2", 32'(b_locked_s), 32'd1);
        chk("sat_lockup",  32'(b_lockup_s), 32'd1);
        do_reset();
        chk("rst_b_err", 32'(b_err_s), 32'd0);

        // Randomised stream: mostly legal, some corruption, some reseeds.
        g = 0;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r = $urandom_range(0, 29);
            if (r == 0)      s = $urandom_range(0, 7);
            else if (r == 1) s = 7;
            else             s = g;
            if (v != 0) g = nxt_tab[g];
            if (r == 2) g = cyc_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 249) == 0) do_reset();
            else drive(v, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
